// File: rtl/axis_image_pkg.sv
// Shared types for the AXI4-Stream image receive/transmit path.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package axis_image_pkg;

    // Default pixel width of the image stream (24-bit RGB).
    localparam int AXIS_DATA_BITS = 24;

    typedef enum logic {
        RX_IDLE   = 1'b0,
        RX_ACTIVE = 1'b1
    } rx_state_e;

    // One stream beat at the default pixel width.
    typedef struct packed {
        logic [AXIS_DATA_BITS-1:0] data;
        logic                      last;
        logic                      user;
    } axis_beat_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// 2-entry register slice, generic width; usable on either side of an image link.
// Latency: 1 cycle from accepted input to valid output; full throughput with no bubbles.
// Backpressure: s_rdy_o = not full (from registered occupancy), forced low while rstn_i=0.
//
// Ports: clk_i/rstn_i (sync active-low reset), s_dat_i/s_vld_i/s_rdy_o upstream,
//        m_dat_o/m_vld_o/m_rdy_i downstream. Output is held stable while m_rdy_i=0.
module axis_skid_buffer #(
    parameter int WIDTH = 26
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] s_dat_i,
    input  logic             s_vld_i,
    output logic             s_rdy_o,
    output logic [WIDTH-1:0] m_dat_o,
    output logic             m_vld_o,
    input  logic             m_rdy_i
);

    logic [1:0][WIDTH-1:0] mem_q, mem_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  push, pop;

    // Ready depends only on registered occupancy, never on s_vld_i.
    assign s_rdy_o = rstn_i & (cnt_q != 2'd2);
    assign m_vld_o = (cnt_q != 2'd0);
    assign m_dat_o = mem_q[rd_ptr_q];

    assign push = s_vld_i & s_rdy_o;
    assign pop  = m_vld_o & m_rdy_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            mem_d[wr_ptr_q] = s_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/axis_image_frame_rx.sv
// AXI4-Stream image receiver: checks SOF(user)/EOL(last) framing against IMG_WIDTH x IMG_HEIGHT.
// Latency: 1 cycle input->output through a 2-entry skid; status (errors, frame_done) 1 cycle after accept.
// Backpressure: axis_s_ready_o = skid not full; output beats held while axis_m_ready_i=0.
//
// Ports: clk_i, rstn_i (sync active-low); axis_s_* slave stream in; axis_m_* master stream out
//        (last/user forwarded unmodified); frame_done_o pulse; sticky err_sof_o/err_eol_o cleared
//        by err_clr_i (a new error in the same cycle wins); frame_cnt_o wraps.
// Build option: define AXIS_IMAGE_FRAME_RX_RESYNC_EN to drop non-SOF beats arriving while idle
// instead of treating them as the start of a frame.
module axis_image_frame_rx
    import axis_image_pkg::*;
#(
    parameter int DATA_BITS  = 24,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int CNT_BITS   = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [DATA_BITS-1:0] axis_s_data_i,
    input  logic                 axis_s_valid_i,
    output logic                 axis_s_ready_o,
    input  logic                 axis_s_last_i,
    input  logic                 axis_s_user_i,
    output logic [DATA_BITS-1:0] axis_m_data_o,
    output logic                 axis_m_valid_o,
    input  logic                 axis_m_ready_i,
    output logic                 axis_m_last_o,
    output logic                 axis_m_user_o,
    output logic                 frame_done_o,
    output logic                 err_sof_o,
    output logic                 err_eol_o,
    input  logic                 err_clr_i,
    output logic [CNT_BITS-1:0]  frame_cnt_o
);

    localparam int                BEAT_W  = DATA_BITS + 2;
    localparam logic [CNT_BITS-1:0] X_LAST  = CNT_BITS'(IMG_WIDTH - 1);
    localparam logic [CNT_BITS-1:0] Y_LAST  = CNT_BITS'(IMG_HEIGHT - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    rx_state_e           state_q, state_d;
    logic [CNT_BITS-1:0] x_q, x_d;
    logic [CNT_BITS-1:0] y_q, y_d;
    logic [CNT_BITS-1:0] frame_cnt_q, frame_cnt_d;
    logic                done_q, done_d;
    logic                err_sof_q, err_sof_d;
    logic                err_eol_q, err_eol_d;

    logic                acc;
    logic                drop;
    logic                track;
    logic                sof_set, eol_set;
    logic [CNT_BITS-1:0] pos, line;
    logic [BEAT_W-1:0]   skid_in_dat, skid_out_dat;

    assign acc = axis_s_valid_i & axis_s_ready_o;

`ifdef AXIS_IMAGE_FRAME_RX_RESYNC_EN
    // Idle beats without SOF are still handshaken but never reach the skid.
    assign drop = (state_q == RX_IDLE) & ~axis_s_user_i;
`else
    assign drop = 1'b0;
`endif

    assign skid_in_dat = {axis_s_data_i, axis_s_last_i, axis_s_user_i};

    axis_skid_buffer #(
        .WIDTH (BEAT_W)
    ) u_skid (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .s_dat_i (skid_in_dat),
        .s_vld_i (axis_s_valid_i & ~drop),
        .s_rdy_o (axis_s_ready_o),
        .m_dat_o (skid_out_dat),
        .m_vld_o (axis_m_valid_o),
        .m_rdy_i (axis_m_ready_i)
    );

    assign axis_m_data_o = skid_out_dat[BEAT_W-1:2];
    assign axis_m_last_o = skid_out_dat[1];
    assign axis_m_user_o = skid_out_dat[0];

    // pos/line are the column/row of the beat being accepted. An SOF beat is
    // column 0 of row 0, which lets a beat that is both SOF and EOL take the
    // SOF restart first and then the line-end check.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        sof_set     = 1'b0;
        eol_set     = 1'b0;
        pos         = x_q;
        line        = y_q;
        track       = 1'b0;

        if (acc) begin
            track = 1'b1;
            if (axis_s_user_i) begin
                sof_set = (state_q == RX_ACTIVE);
                pos     = '0;
                line    = '0;
            end else if (state_q == RX_IDLE) begin
                sof_set = 1'b1;
`ifdef AXIS_IMAGE_FRAME_RX_RESYNC_EN
                track   = 1'b0;
`else
                pos     = '0;
                line    = '0;
`endif
            end
        end

        if (track) begin
            state_d = RX_ACTIVE;
            if ((pos == X_LAST) || axis_s_last_i) begin
                // Any line end (normal, early or late) advances the row.
                eol_set = (pos != X_LAST) || !axis_s_last_i;
                x_d     = '0;
                if (line == Y_LAST) begin
                    y_d         = '0;
                    state_d     = RX_IDLE;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + CNT_ONE;
                end else begin
                    y_d = line + CNT_ONE;
                end
            end else begin
                x_d = pos + CNT_ONE;
            end
        end

        err_sof_d = sof_set | (err_sof_q & ~err_clr_i);
        err_eol_d = eol_set | (err_eol_q & ~err_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= RX_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
            err_sof_q   <= 1'b0;
            err_eol_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
            err_sof_q   <= err_sof_d;
            err_eol_q   <= err_eol_d;
        end
    end

    assign frame_done_o = done_q;
    assign err_sof_o    = err_sof_q;
    assign err_eol_o    = err_eol_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule
